// File: rtl/pong_frame_decoder_pkg.sv
// Shared frame layout, state encoding and checksum helper for the pong UART link.
// FRAME_CHECKSUM_EN selects the 5-byte frame with a trailing XOR byte.
package pong_link_pkg;

`ifdef FRAME_CHECKSUM_EN
  localparam int FRAME_BYTES = 5;
`else
  localparam int FRAME_BYTES = 4;
`endif

  localparam int CNT_W      = $clog2(FRAME_BYTES);
  localparam int X_LSB      = 1;
  localparam int X_W        = 11;
  localparam int Y_BALL_LSB = 12;
  localparam int Y_PAD_LSB  = 22;
  localparam int Y_W        = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  typedef struct packed {
    logic [Y_W-1:0] y_pad;
    logic [Y_W-1:0] y_ball;
    logic [X_W-1:0] x_ball;
    logic           marker;
  } frame_t;

  function automatic logic [7:0] frame_xor(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

endpackage

// File: rtl/pong_frame_decoder_tick_timeout.sv
// Saturating timing_tick counter; hit flags the tick that brings it to LIMIT.
module tick_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic hit
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign hit = tick && !clr && (count == W'(LIMIT - 1));

  // Clear dominates; otherwise count ticks until the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pong_frame_decoder.sv
// Receive-side game-state frame decoder with byte-gap and link-health watchdogs.
// Build option: FRAME_CHECKSUM_EN (5-byte frame with XOR check byte).
module pong_frame_decoder
  import pong_link_pkg::*;
#(
  parameter int          GAP_TICKS  = 16,
  parameter int          LINK_TICKS = 120,
  parameter logic [9:0]  Y_RST      = 10'd300,
  parameter logic [10:0] X_RST      = 11'd512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [9:0]  y_pad_remote,
  output logic [9:0]  y_ball,
  output logic [10:0] x_ball,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link_up
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       held [FRAME_BYTES];
  logic [7:0]       cand [FRAME_BYTES];
  logic [31:0]      word;
  frame_t           frame;
  logic             frame_ok, store_byte, load_good, load_bad;
  logic             gap_clr, gap_hit, link_hit;

  // The frame is judged in the same cycle its last byte arrives, so the
  // incoming byte is merged into the held bytes before checking.
  always_comb begin
    for (int k = 0; k < FRAME_BYTES; k++) begin
      cand[k] = (byte_cnt == CNT_W'(k)) ? rx_data : held[k];
    end
    word         = {cand[3], cand[2], cand[1], cand[0]};
    frame.marker = word[0];
    frame.x_ball = word[X_LSB +: X_W];
    frame.y_ball = word[Y_BALL_LSB +: Y_W];
    frame.y_pad  = word[Y_PAD_LSB +: Y_W];
`ifdef FRAME_CHECKSUM_EN
    frame_ok = frame.marker && (cand[FRAME_BYTES-1] == frame_xor(word));
`else
    frame_ok = frame.marker;
`endif
  end

  // Next-state and load/error decisions.
  always_comb begin
    state_next = state;
    store_byte = 1'b0;
    load_good  = 1'b0;
    load_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_done && rx_data[0]) begin
          store_byte = 1'b1;
          state_next = S_COLLECT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (rx_done) begin
          store_byte = 1'b1;
          if (byte_cnt == CNT_LAST) begin
            state_next = S_CHECK;
            load_good  = frame_ok;
            load_bad   = !frame_ok;
          end else begin
            state_next = S_COLLECT;
          end
        end else if (gap_hit) begin
          load_bad   = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_COLLECT;
        end
      end
      S_CHECK: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign gap_clr = rx_done || (state != S_COLLECT);

  tick_timeout #(.LIMIT(GAP_TICKS)) u_gap_wd (
    .clk  (clk),
    .rst  (rst),
    .clr  (gap_clr),
    .tick (timing_tick),
    .hit  (gap_hit)
  );

  tick_timeout #(.LIMIT(LINK_TICKS)) u_link_wd (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_good),
    .tick (timing_tick),
    .hit  (link_hit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Byte capture; the count returns to zero whenever collection ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      for (int k = 0; k < FRAME_BYTES; k++) begin
        held[k] <= 8'h00;
      end
    end else if (store_byte) begin
      held[byte_cnt] <= rx_data;
      byte_cnt       <= (byte_cnt == CNT_LAST) ? '0 : byte_cnt + CNT_ONE;
    end else if (state_next != S_COLLECT) begin
      byte_cnt <= '0;
    end
  end

  // Registered outputs: coordinates change only as a whole on a good frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_pad_remote <= Y_RST;
      y_ball       <= Y_RST;
      x_ball       <= X_RST;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      link_up      <= 1'b0;
    end else begin
      frame_valid <= load_good;
      frame_err   <= load_bad;
      if (load_good) begin
        y_pad_remote <= frame.y_pad;
        y_ball       <= frame.y_ball;
        x_ball       <= frame.x_ball;
      end
      if (load_good) begin
        link_up <= 1'b1;
      end else if (link_hit) begin
        link_up <= 1'b0;
      end
    end
  end

endmodule
